// File: rtl/axi_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_regfile
// Purpose  : AXI-Lite slave register bank. Holds NUM_REGS software-visible
//            words, exports them in parallel to downstream logic and pulses a
//            per-register strobe on every committed write. Write and read
//            channels run independently; AW and W may arrive in any order.
// Ports    : clk, rst_n (async, active low)
//            aw_addr/aw_valid/aw_ready         - write address channel
//            w_data/w_strb/w_valid/w_ready     - write data channel
//            b_resp/b_valid/b_ready            - write response channel
//            ar_addr/ar_valid/ar_ready         - read address channel
//            r_data/r_resp/r_valid/r_ready     - read data channel
//            reg_out    - flat register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//            reg_wr_stb - one-cycle pulse per committed write to reg i
// Options  : AXIL_REGFILE_DECERR_EN - out-of-range accesses answer DECERR
//            (2'b11) instead of OKAY.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_regfile #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_WIDTH-1:0]          aw_addr,
    input  logic                           aw_valid,
    output logic                           aw_ready,
    input  logic [DATA_WIDTH-1:0]          w_data,
    input  logic [DATA_WIDTH/8-1:0]        w_strb,
    input  logic                           w_valid,
    output logic                           w_ready,
    output logic [1:0]                     b_resp,
    output logic                           b_valid,
    input  logic                           b_ready,
    input  logic [ADDR_WIDTH-1:0]          ar_addr,
    input  logic                           ar_valid,
    output logic                           ar_ready,
    output logic [DATA_WIDTH-1:0]          r_data,
    output logic [1:0]                     r_resp,
    output logic                           r_valid,
    input  logic                           r_ready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            reg_wr_stb
);

    localparam int         c_STRB_W    = DATA_WIDTH / 8;
    localparam int         c_OFF_BITS  = $clog2(c_STRB_W);
    localparam logic [1:0] c_RESP_OKAY = 2'b00;
`ifdef AXIL_REGFILE_DECERR_EN
    localparam logic [1:0] c_RESP_OOR  = 2'b11;
`else
    localparam logic [1:0] c_RESP_OOR  = 2'b00;
`endif

    localparam logic [0:0] c_W_IDLE = 1'b0;
    localparam logic [0:0] c_W_RESP = 1'b1;
    localparam logic [0:0] c_R_IDLE = 1'b0;
    localparam logic [0:0] c_R_RESP = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]            r_wstate;
    logic [0:0]            r_rstate;
    logic                  r_aw_held;
    logic                  r_w_held;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic [c_STRB_W-1:0]   r_w_strb;
    logic [1:0]            r_b_resp;
    logic [DATA_WIDTH-1:0] r_r_data;
    logic [1:0]            r_r_resp;
    logic [NUM_REGS-1:0]   r_wr_stb;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic [0:0]            w_wstate_nxt;
    logic [0:0]            w_rstate_nxt;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [c_STRB_W-1:0]   w_wr_strb;
    logic [ADDR_WIDTH-1:0] w_wr_word;
    logic [ADDR_WIDTH-1:0] w_rd_word;
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic [NUM_REGS-1:0]   w_wr_sel;
    logic [DATA_WIDTH-1:0] w_rd_val;

    // Ready signals depend on registered state only.
    assign aw_ready = (r_wstate == c_W_IDLE) && !r_aw_held;
    assign w_ready  = (r_wstate == c_W_IDLE) && !r_w_held;
    assign ar_ready = (r_rstate == c_R_IDLE);

    assign b_valid  = (r_wstate == c_W_RESP);
    assign r_valid  = (r_rstate == c_R_RESP);
    assign b_resp   = r_b_resp;
    assign r_data   = r_r_data;
    assign r_resp   = r_r_resp;
    assign reg_wr_stb = r_wr_stb;

    assign w_aw_hs = aw_valid && aw_ready;
    assign w_w_hs  = w_valid && w_ready;
    assign w_ar_hs = ar_valid && ar_ready;

    // Commit when both halves are available, whether held from an earlier
    // handshake or handshaking right now.
    assign w_commit = (r_wstate == c_W_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

    assign w_wr_addr = r_aw_held ? r_aw_addr : aw_addr;
    assign w_wr_data = r_w_held  ? r_w_data  : w_data;
    assign w_wr_strb = r_w_held  ? r_w_strb  : w_strb;

    // Word index over the full address width: any set high bit makes the
    // index exceed NUM_REGS, so a single compare covers the range check.
    assign w_wr_word     = w_wr_addr >> c_OFF_BITS;
    assign w_rd_word     = ar_addr >> c_OFF_BITS;
    assign w_wr_in_range = (w_wr_word < ADDR_WIDTH'(NUM_REGS));
    assign w_rd_in_range = (w_rd_word < ADDR_WIDTH'(NUM_REGS));

    // One-hot write select and read mux; an out-of-range index matches no
    // register, so writes are dropped and reads yield zero.
    always_comb begin
        w_wr_sel = '0;
        w_rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_commit && (w_wr_word == ADDR_WIDTH'(i))) begin
                w_wr_sel[i] = 1'b1;
            end
            if (w_rd_word == ADDR_WIDTH'(i)) begin
                w_rd_val = r_regs[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------------
    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            c_W_IDLE: if (w_commit) w_wstate_nxt = c_W_RESP;
            c_W_RESP: if (b_ready)  w_wstate_nxt = c_W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate <= c_W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_addr <= '0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_b_resp  <= c_RESP_OKAY;
            r_wr_stb  <= '0;
        end else begin
            // The select is only non-zero on the commit edge, so the strobe
            // lasts exactly one cycle.
            r_wr_stb <= w_wr_sel;
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_b_resp  <= w_wr_in_range ? c_RESP_OKAY : c_RESP_OOR;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_addr <= aw_addr;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_w_data <= w_data;
                    r_w_strb <= w_strb;
                end
            end
        end
    end

    // Register bank with per-lane byte enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_sel[i]) begin
                    for (int k = 0; k < c_STRB_W; k++) begin
                        if (w_wr_strb[k]) begin
                            r_regs[i][k*8 +: 8] <= w_wr_data[k*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------------
    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            c_R_IDLE: if (w_ar_hs) w_rstate_nxt = c_R_RESP;
            c_R_RESP: if (r_ready) w_rstate_nxt = c_R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate <= c_R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    // Payload is captured only on the AR handshake, which samples the
    // pre-edge register value even if a write commits on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r_data <= '0;
            r_r_resp <= c_RESP_OKAY;
        end else if (w_ar_hs) begin
            r_r_data <= w_rd_val;
            r_r_resp <= w_rd_in_range ? c_RESP_OKAY : c_RESP_OOR;
        end
    end

    // ------------------------------------------------------------------------
    // Parallel export
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
            assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_regfile
// Purpose  : Directed self-checking bench for axi_lite_regfile (32-bit data,
//            16 registers). Expected values are written out by hand.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_regfile;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;
`ifdef AXIL_REGFILE_DECERR_EN
    localparam logic [1:0] c_OOR_RESP = 2'b11;
`else
    localparam logic [1:0] c_OOR_RESP = 2'b00;
`endif

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] aw_addr;
    logic          aw_valid;
    logic          aw_ready;
    logic [DW-1:0] w_data;
    logic [DW/8-1:0] w_strb;
    logic          w_valid;
    logic          w_ready;
    logic [1:0]    b_resp;
    logic          b_valid;
    logic          b_ready;
    logic [AW-1:0] ar_addr;
    logic          ar_valid;
    logic          ar_ready;
    logic [DW-1:0] r_data;
    logic [1:0]    r_resp;
    logic          r_valid;
    logic          r_ready;
    logic [NR*DW-1:0] reg_out;
    logic [NR-1:0] reg_wr_stb;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] exp_regs [NR];
    logic          obs_bvalid, obs_bvalid_after;
    logic [1:0]    obs_bresp, obs_rresp;
    logic [NR-1:0] obs_stb, obs_stb_after;
    logic          obs_rvalid;
    logic [DW-1:0] obs_rdata;

    axi_lite_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
        .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
        .reg_out(reg_out), .reg_wr_stb(reg_wr_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [NR*DW-1:0] flat_exp();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = exp_regs[i];
        return v;
    endfunction

    // Drive helpers: inputs change 1 time unit after the rising edge,
    // outputs are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        aw_addr = a; aw_valid = 1'b1; w_data = d; w_strb = s; w_valid = 1'b1;
        step();
        aw_valid = 1'b0; w_valid = 1'b0;
        obs_bvalid = b_valid; obs_bresp = b_resp; obs_stb = reg_wr_stb;
        b_ready = 1'b1;
        step();
        b_ready = 1'b0;
        obs_bvalid_after = b_valid; obs_stb_after = reg_wr_stb;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        ar_addr = a; ar_valid = 1'b1;
        step();
        ar_valid = 1'b0;
        obs_rvalid = r_valid; obs_rdata = r_data; obs_rresp = r_resp;
        r_ready = 1'b1;
        step();
        r_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        for (int i = 0; i < NR; i++) exp_regs[i] = '0;
        checks++; if ({aw_ready, w_ready, ar_ready} !== 3'b111) begin errors++; $display("FAIL reset_ready: got %b expected 111", {aw_ready, w_ready, ar_ready}); end
        checks++; if ({b_valid, r_valid} !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b expected 00", {b_valid, r_valid}); end
        checks++; if (reg_out !== flat_exp()) begin errors++; $display("FAIL reset_regs: got %h expected 0", reg_out); end
        checks++; if ({reg_wr_stb, r_data, b_resp, r_resp} !== '0) begin errors++; $display("FAIL reset_payload: stb %h rdata %h bresp %b rresp %b expected 0", reg_wr_stb, r_data, b_resp, r_resp); end
    endtask

    task automatic test_write_read();
        do_write(32'h08, 32'hDEADBEEF, 4'hF);
        exp_regs[2] = 32'hDEADBEEF;
        checks++; if ({obs_bvalid, obs_bresp} !== 3'b100) begin errors++; $display("FAIL wr_bresp: got valid/resp %b expected 100", {obs_bvalid, obs_bresp}); end
        checks++; if (obs_stb !== 16'h0004) begin errors++; $display("FAIL wr_stb: got %h expected 0004", obs_stb); end
        checks++; if ({obs_bvalid_after, obs_stb_after} !== 17'h0) begin errors++; $display("FAIL wr_after: got bvalid %b stb %h expected 0 0000", obs_bvalid_after, obs_stb_after); end
        checks++; if (reg_out !== flat_exp()) begin errors++; $display("FAIL wr_regs: got %h expected %h", reg_out, flat_exp()); end
        do_read(32'h08);
        checks++; if ({obs_rvalid, obs_rresp} !== 3'b100) begin errors++; $display("FAIL rd_resp: got %b expected 100", {obs_rvalid, obs_rresp}); end
        checks++; if (obs_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", obs_rdata); end
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL rd_release: got r_valid %b expected 0", r_valid); end
    endtask

    task automatic test_ordering();
        // W first, AW three cycles later
        w_data = 32'h11223344; w_strb = 4'hF; w_valid = 1'b1;
        step();
        w_valid = 1'b0;
        checks++; if ({w_ready, aw_ready, b_valid} !== 3'b010) begin errors++; $display("FAIL wfirst_ready: got w/aw/b %b expected 010", {w_ready, aw_ready, b_valid}); end
        for (int c = 0; c < 2; c++) begin
            step();
            checks++; if ({b_valid, reg_wr_stb} !== 17'h0) begin errors++; $display("FAIL wfirst_wait: got bvalid %b stb %h expected 0 0000", b_valid, reg_wr_stb); end
        end
        aw_addr = 32'h04; aw_valid = 1'b1;
        step();
        aw_valid = 1'b0;
        checks++; if ({b_valid, reg_wr_stb} !== {1'b1, 16'h0002}) begin errors++; $display("FAIL wfirst_commit: got bvalid %b stb %h expected 1 0002", b_valid, reg_wr_stb); end
        checks++; if (reg_out[1*DW +: DW] !== 32'h11223344) begin errors++; $display("FAIL wfirst_reg: got %h expected 11223344", reg_out[1*DW +: DW]); end
        b_ready = 1'b1; step(); b_ready = 1'b0;
        // clear, then AW first
        do_write(32'h04, 32'h0, 4'hF);
        checks++; if (reg_out[1*DW +: DW] !== 32'h0) begin errors++; $display("FAIL clr_reg: got %h expected 0", reg_out[1*DW +: DW]); end
        aw_addr = 32'h04; aw_valid = 1'b1;
        step();
        aw_valid = 1'b0;
        checks++; if ({aw_ready, w_ready, b_valid} !== 3'b010) begin errors++; $display("FAIL awfirst_ready: got aw/w/b %b expected 010", {aw_ready, w_ready, b_valid}); end
        step();
        w_data = 32'h11223344; w_strb = 4'hF; w_valid = 1'b1;
        step();
        w_valid = 1'b0;
        exp_regs[1] = 32'h11223344;
        checks++; if ({b_valid, reg_wr_stb} !== {1'b1, 16'h0002}) begin errors++; $display("FAIL awfirst_commit: got bvalid %b stb %h expected 1 0002", b_valid, reg_wr_stb); end
        checks++; if (reg_out !== flat_exp()) begin errors++; $display("FAIL awfirst_regs: got %h expected %h", reg_out, flat_exp()); end
        b_ready = 1'b1; step(); b_ready = 1'b0;
    endtask

    task automatic test_strobes();
        do_write(32'h0C, 32'hAABBCCDD, 4'hF);
        do_write(32'h0C, 32'h11223344, 4'b0101);
        exp_regs[3] = 32'hAA22CC44;
        do_read(32'h0C);
        checks++; if (obs_rdata !== 32'hAA22CC44) begin errors++; $display("FAIL strb_read: got %h expected aa22cc44", obs_rdata); end
        // all-zero strobe: pulse and OKAY, no data change
        do_write(32'h0C, 32'hFFFFFFFF, 4'h0);
        checks++; if ({obs_stb, obs_bresp} !== {16'h0008, 2'b00}) begin errors++; $display("FAIL strb0_stb: got stb %h resp %b expected 0008 00", obs_stb, obs_bresp); end
        checks++; if (reg_out !== flat_exp()) begin errors++; $display("FAIL strb0_regs: got %h expected %h", reg_out, flat_exp()); end
    endtask

    task automatic test_same_reg();
        aw_addr = 32'h08; w_data = 32'h12345678; w_strb = 4'hF; ar_addr = 32'h08;
        aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
        step();
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        exp_regs[2] = 32'h12345678;
        checks++; if ({b_valid, r_valid} !== 2'b11) begin errors++; $display("FAIL same_valid: got %b expected 11", {b_valid, r_valid}); end
        checks++; if (r_data !== 32'hDEADBEEF) begin errors++; $display("FAIL same_rdata: got %h expected deadbeef", r_data); end
        checks++; if (reg_out !== flat_exp()) begin errors++; $display("FAIL same_regs: got %h expected %h", reg_out, flat_exp()); end
        b_ready = 1'b1; r_ready = 1'b1; step(); b_ready = 1'b0; r_ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        aw_addr = 32'h14; w_data = 32'h5A5A1234; w_strb = 4'hF; ar_addr = 32'h0C;
        aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
        step();
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        exp_regs[5] = 32'h5A5A1234;
        for (int c = 0; c < 5; c++) begin
            checks++; if ({b_valid, b_resp, r_valid, r_resp, aw_ready, w_ready, ar_ready} !== 9'b1_00_1_00_000) begin errors++; $display("FAIL bp_hold cycle %0d: got %b expected 100100000", c, {b_valid, b_resp, r_valid, r_resp, aw_ready, w_ready, ar_ready}); end
            checks++; if (r_data !== 32'hAA22CC44) begin errors++; $display("FAIL bp_rdata cycle %0d: got %h expected aa22cc44", c, r_data); end
            step();
        end
        b_ready = 1'b1; r_ready = 1'b1; step(); b_ready = 1'b0; r_ready = 1'b0;
        checks++; if ({b_valid, r_valid, aw_ready, w_ready, ar_ready} !== 5'b00111) begin errors++; $display("FAIL bp_release: got %b expected 00111", {b_valid, r_valid, aw_ready, w_ready, ar_ready}); end
        checks++; if (reg_out !== flat_exp()) begin errors++; $display("FAIL bp_regs: got %h expected %h", reg_out, flat_exp()); end
    endtask

    task automatic test_out_of_range();
        do_write(32'h40, 32'hFFFFFFFF, 4'hF);
        checks++; if ({obs_bvalid, obs_bresp, obs_stb} !== {1'b1, c_OOR_RESP, 16'h0}) begin errors++; $display("FAIL oor_wr: got valid %b resp %b stb %h expected 1 %b 0000", obs_bvalid, obs_bresp, obs_stb, c_OOR_RESP); end
        do_write(32'h80000008, 32'hFFFFFFFF, 4'hF);
        checks++; if ({obs_bresp, obs_stb} !== {c_OOR_RESP, 16'h0}) begin errors++; $display("FAIL oor_hi_wr: got resp %b stb %h expected %b 0000", obs_bresp, obs_stb, c_OOR_RESP); end
        checks++; if (reg_out !== flat_exp()) begin errors++; $display("FAIL oor_regs: got %h expected %h", reg_out, flat_exp()); end
        do_read(32'h40);
        checks++; if ({obs_rdata, obs_rresp} !== {32'h0, c_OOR_RESP}) begin errors++; $display("FAIL oor_rd: got %h/%b expected 0/%b", obs_rdata, obs_rresp, c_OOR_RESP); end
        do_read(32'h80000008);
        checks++; if ({obs_rdata, obs_rresp} !== {32'h0, c_OOR_RESP}) begin errors++; $display("FAIL oor_hi_rd: got %h/%b expected 0/%b", obs_rdata, obs_rresp, c_OOR_RESP); end
        // last register, with low offset bits set on the read
        do_write(32'h3C, 32'hF00DF00D, 4'hF);
        exp_regs[15] = 32'hF00DF00D;
        checks++; if ({obs_stb, obs_bresp} !== {16'h8000, 2'b00}) begin errors++; $display("FAIL last_wr: got stb %h resp %b expected 8000 00", obs_stb, obs_bresp); end
        do_read(32'h3F);
        checks++; if ({obs_rdata, obs_rresp} !== {32'hF00DF00D, 2'b00}) begin errors++; $display("FAIL last_rd: got %h/%b expected f00df00d/00", obs_rdata, obs_rresp); end
    endtask

    task automatic test_reset_mid();
        aw_addr = 32'h10; w_data = 32'h0000CAFE; w_strb = 4'hF; aw_valid = 1'b1; w_valid = 1'b1;
        step();
        aw_valid = 1'b0; w_valid = 1'b0;
        checks++; if ({b_valid, reg_wr_stb} !== {1'b1, 16'h0010}) begin errors++; $display("FAIL mid_pre: got bvalid %b stb %h expected 1 0010", b_valid, reg_wr_stb); end
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NR; i++) exp_regs[i] = '0;
        checks++; if ({b_valid, r_valid, aw_ready, w_ready, ar_ready} !== 5'b00111) begin errors++; $display("FAIL mid_rst_ctl: got %b expected 00111", {b_valid, r_valid, aw_ready, w_ready, ar_ready}); end
        checks++; if ({reg_wr_stb, r_data, b_resp, r_resp} !== '0) begin errors++; $display("FAIL mid_rst_payload: stb %h rdata %h expected 0", reg_wr_stb, r_data); end
        checks++; if (reg_out !== flat_exp()) begin errors++; $display("FAIL mid_rst_regs: got %h expected 0", reg_out); end
        step(); rst_n = 1'b1;
        step();
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_b: got %b expected 0", b_valid); end
        // held W data must be discarded by reset
        w_data = 32'h77; w_strb = 4'hF; w_valid = 1'b1;
        step();
        w_valid = 1'b0;
        checks++; if (w_ready !== 1'b0) begin errors++; $display("FAIL mid_wheld: got w_ready %b expected 0", w_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL mid_wclr: got w_ready %b expected 1", w_ready); end
        step(); rst_n = 1'b1;
        aw_addr = 32'h10; aw_valid = 1'b1;
        step();
        aw_valid = 1'b0;
        checks++; if ({b_valid, aw_ready, w_ready} !== 3'b001) begin errors++; $display("FAIL mid_no_stale: got b/aw/w %b expected 001", {b_valid, aw_ready, w_ready}); end
        checks++; if (reg_out !== flat_exp()) begin errors++; $display("FAIL mid_no_write: got %h expected 0", reg_out); end
        w_data = 32'h99; w_valid = 1'b1;
        step();
        w_valid = 1'b0;
        exp_regs[4] = 32'h99;
        checks++; if ({b_valid, reg_wr_stb} !== {1'b1, 16'h0010}) begin errors++; $display("FAIL mid_finish: got bvalid %b stb %h expected 1 0010", b_valid, reg_wr_stb); end
        checks++; if (reg_out !== flat_exp()) begin errors++; $display("FAIL mid_finish_regs: got %h expected %h", reg_out, flat_exp()); end
        b_ready = 1'b1; step(); b_ready = 1'b0;
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL mid_bdone: got %b expected 0", b_valid); end
    endtask

    initial begin
        rst_n = 1'b0;
        aw_addr = '0; aw_valid = 1'b0; w_data = '0; w_strb = '0; w_valid = 1'b0; b_ready = 1'b0;
        ar_addr = '0; ar_valid = 1'b0; r_ready = 1'b0;
        #12;
        test_reset();
        step();
        rst_n = 1'b1;
        step();
        test_write_read();
        test_ordering();
        test_strobes();
        test_same_reg();
        test_back_pressure();
        test_out_of_range();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_regfile.md
# axi_lite_regfile

AXI-Lite slave register bank that terminates the slave side of `axi_lite_if` and holds `NUM_REGS` software-visible control/status words. Write and read channels are independent. Write address and write data are accepted in either order or together. Byte strobes apply per lane. The register contents are exported in parallel to downstream logic, along with per-register write pulses.

## Interface
- `ADDR_WIDTH`, default 32: AXI address width.
- `DATA_WIDTH`, default 32: register and data width; 32 or 64 only.
- `NUM_REGS`, default 16: number of registers, range 1..256.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous active-low reset.
- `aw_addr` in ADDR_WIDTH; `aw_valid` in 1; `aw_ready` out 1: write address channel.
- `w_data` in DATA_WIDTH; `w_strb` in DATA_WIDTH/8; `w_valid` in 1; `w_ready` out 1: write data channel.
- `b_resp` out 2; `b_valid` out 1; `b_ready` in 1: write response channel.
- `ar_addr` in ADDR_WIDTH; `ar_valid` in 1; `ar_ready` out 1: read address channel.
- `r_data` out DATA_WIDTH; `r_resp` out 2; `r_valid` out 1; `r_ready` in 1: read data channel.
- `reg_out` out NUM_REGS*DATA_WIDTH: flat register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `reg_wr_stb` out NUM_REGS: one-cycle pulse on each committed write to register i.

## Operation
- **Address decode.** `idx = addr >> log2(DATA_WIDTH/8)`. Low byte-offset bits are ignored. The address is in range iff `idx < NUM_REGS` and every higher address bit is 0.
- **Write FSM, states W_IDLE and W_RESP.**
  - In W_IDLE: `aw_ready = !aw_held`; `w_ready = !w_held`.
  - An AW handshake alone captures the address and sets `aw_held`. A W handshake alone captures the data and strobe and sets `w_held`.
  - On the edge where both AW and W are available (held, or handshaking this cycle, in any combination), the write commits and the FSM enters W_RESP.
    - Commit: for each lane k with `w_strb[k]=1`, byte k of the register ← byte k of `w_data`. Lanes with strobe 0 are unchanged.
    - Side effects on the same edge: `reg_wr_stb[idx]` pulses for one cycle; `b_valid` ← 1; both held flags clear.
  - An all-zero strobe still commits as a no-change write: `reg_wr_stb` pulses and the response is OKAY.
  - In W_RESP: `aw_ready = w_ready = 0`. On `b_valid && b_ready`, `b_valid` ← 0 and the FSM returns to W_IDLE.
- **Read FSM, states R_IDLE and R_RESP.**
  - In R_IDLE: `ar_ready = 1`.
  - On AR handshake, `r_data` ← register[idx] (the pre-edge value) and `r_valid` ← 1; the FSM enters R_RESP.
  - In R_RESP: `ar_ready = 0`. `r_data` and `r_resp` are held stable until `r_ready`, then `r_valid` ← 0 and the FSM returns to R_IDLE.
- **Simultaneous read and write to the same register.** The read returns the old value; the write commits on the same edge.
- **Out-of-range access.** Writes do not modify any register and do not pulse `reg_wr_stb`. Reads return `r_data = 0`. The `resp` code is set per the Configuration section.
- **Reset values.**
  - All registers, `reg_out`, `reg_wr_stb`, `b_valid`, `r_valid`, `b_resp`, `r_resp`, `r_data` = 0.
  - Both FSMs are idle with held flags clear, so `aw_ready = w_ready = ar_ready = 1`.
  - Any in-flight transaction is discarded when reset asserts mid-operation; no response is issued after reset.

## Timing
- `aw_ready`, `w_ready`, `ar_ready` are combinational decodes of registered state only; there is no combinational path from any input.
- `b_valid` rises one cycle after the later of the AW and W handshakes. With `b_ready` held high, throughput is one write per 2 cycles.
- `r_valid` rises one cycle after the AR handshake. With `r_ready` held high, throughput is one read per 2 cycles.
- The register update is visible on `reg_out` in the same cycle that `b_valid` first asserts. `reg_wr_stb` is high in exactly that cycle.
- `b_resp`, `r_resp`, `r_data` change only on the edge where the corresponding `valid` rises.

## Configuration
- **With `AXIL_REGFILE_DECERR_EN` defined:** out-of-range writes and reads respond `2'b11` (DECERR).
- **Without it:** out-of-range accesses respond `2'b00` (OKAY). Writes are silently dropped and reads return 0.
- In-range accesses always respond OKAY in both builds.

## Test plan
- **Write then read, aligned.**
  - Stimulus: AW and W in the same cycle, addr 0x08, data 0xDEADBEEF, strb 0xF; then AR at 0x08.
  - Required: `b_valid` 1 cycle later with `b_resp` 00; `reg_wr_stb[2]` pulses once; `r_data` = 0xDEADBEEF with `r_resp` 00.
- **Ordering independence.**
  - Stimulus: W first (0x11223344), AW 3 cycles later at 0x04; repeat with AW first.
  - Required: `w_ready` drops after the W handshake and the write commits only after AW; both orders give register[1] = 0x11223344.
- **Byte strobes.**
  - Stimulus: register[3] = 0xAABBCCDD, then write 0x11223344 with strb 0b0101.
  - Required: readback = 0xAA22CC44.
- **Back-pressure.**
  - Stimulus: `b_ready` and `r_ready` held low for 5 cycles.
  - Required: `b_valid`/`r_valid` and their payloads are stable throughout; `aw_ready`, `w_ready`, `ar_ready` stay 0 until the response handshake completes.
- **Out of range.**
  - Stimulus: with NUM_REGS=16, write and read at 0x40.
  - Required: no register changes and no `reg_wr_stb` pulse; `r_data` = 0; resp = 11 with the macro defined, 00 without.
- **Reset mid-transaction.**
  - Stimulus: assert `rst_n` low while `b_valid` = 1 and W is held.
  - Required: immediately all outputs take their reset values and all registers = 0; after release, no stale `b_valid`.
